// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full-adder cell, a carry flip-flop and three
// shift registers, processing one bit pair per clock, LSB first.
// Optional build macro: SERIAL_ADDER_OVF_EN adds a signed-overflow output (ovf).

// 1-bit full-adder cell shared by every bit position of the serial adder.
module fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    // A counter of at least one bit, wide enough to hold N-1.
    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  a_sh_q, a_sh_d;
    logic [N-1:0]  b_sh_q, b_sh_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          carry_q, carry_d;

    logic          fa_sum;
    logic          fa_cout;
    logic          load_op;
    logic          last_shift;

    // The single adder cell always sees the current LSB pair and stored carry.
    fa u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // start is only honoured outside SHIFT; the last shift is count == N-1.
    assign load_op    = start && (state_q != S_SHIFT);
    assign last_shift = (state_q == S_SHIFT) && (count_q == LAST);

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave a value unassigned and infer a latch.
        state_d = state_q;
        count_d = count_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load_op) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    sum_d   = '0;
                    count_d = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                a_sh_d         = a_sh_q >> 1;
                b_sh_d         = b_sh_q >> 1;
                // Shift right and insert the new sum bit at the MSB; works for N=1 too.
                sum_d          = sum_q >> 1;
                sum_d[N-1]     = fa_sum;
                carry_d        = fa_cout;
                count_d        = count_q + CW'(1);
                if (last_shift) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy = (state_q == S_SHIFT);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    // The carry flip-flop holds the final carry from the last shift until the next load.
    assign cout = carry_q;

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: carry into the MSB (stored carry) XOR carry out of the MSB.
    always_comb begin
        ovf_d = ovf_q;
        if (load_op) begin
            ovf_d = 1'b0;
        end else if (last_shift) begin
            ovf_d = carry_q ^ fa_cout;
        end
    end

    // Overflow flag register, held alongside sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: table vectors, hand-written
// multi-cycle sequences, random operands against an arithmetic model, and an
// exhaustive sweep of an N=1 instance. Honours SERIAL_ADDER_OVF_EN.
module tb_serial_adder_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;

    logic         start1;
    logic [0:0]   a1;
    logic [0:0]   b1;
    logic         cin1;
    logic         busy1;
    logic         done1;
    logic [0:0]   sum1;
    logic         cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder_ctrl #(.N(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         cin;
        logic [N-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold start for exactly one accepting edge.
    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input logic icin);
        a     = ia;
        b     = ib;
        cin   = icin;
        start = 1'b1;
        step();
        start = 1'b0;
        a     = N'($urandom);
        b     = N'($urandom);
        cin   = 1'($urandom);
    endtask

    // Wait for done, bounded; busy must stay high every cycle before it.
    task automatic wait_done(input string name, input int exp_lat);
        int cyc;
        int not_busy;
        cyc      = 0;
        not_busy = 0;
        while (done !== 1'b1 && cyc < 4 * N) begin
            if (busy !== 1'b1) not_busy++;
            step();
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        check({name, " busy_before_done"}, 64'(not_busy), 64'd0);
        check({name, " busy_low_in_done"}, 64'(busy), 64'd0);
    endtask

    task automatic check_res(input string name, input logic [N-1:0] es, input logic ec, input logic eo);
        check({name, " sum"}, 64'(sum), 64'(es));
        check({name, " cout"}, 64'(cout), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check({name, " ovf"}, 64'(ovf), 64'(eo));
`else
        if (eo === 1'bx) $display("note: %s has unknown ovf expectation", name);
`endif
    endtask

    // One full operation followed by a cycle confirming the single-cycle done pulse.
    task automatic run_op(input string name, input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic icin, input logic [N-1:0] es, input logic ec, input logic eo);
        issue(ia, ib, icin);
        wait_done(name, N);
        check_res(name, es, ec, eo);
        step();
        check({name, " done_pulse"}, 64'(done), 64'd0);
        check({name, " sum_held"}, 64'(sum), 64'(es));
    endtask

    // Reference: plain unsigned addition and signed-range overflow test.
    function automatic logic [N:0] add_ref(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    endfunction

    function automatic logic ovf_ref(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
        longint v;
        v = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
        return (v > (2 ** (N - 1)) - 1) || (v < -(2 ** (N - 1)));
    endfunction

    vec_t tbl[6];

    initial begin
        logic [N:0] ref_full;
        int         done_seen;

        tbl[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

        reset  = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;

        // Reset held two cycles, then released.
        step();
        step();
        reset = 1'b0;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check_res("reset", 8'h00, 1'b0, 1'b0);

        // Table-driven vectors.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                   tbl[i].exp_sum, tbl[i].exp_cout, tbl[i].exp_ovf);
        end

        // Back-to-back: start held during DONE launches the next addition.
        issue(8'h5A, 8'hA5, 1'b1);
        wait_done("b2b first", N);
        check_res("b2b first", 8'h00, 1'b1, 1'b0);
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b relaunch busy", 64'(busy), 64'd1);
        wait_done("b2b second", N);
        check_res("b2b second", 8'h46, 1'b0, 1'b0);
        step();

        // start pulsed mid-SHIFT is ignored.
        issue(8'h0F, 8'h01, 1'b0);
        step();
        step();
        step();
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("ignored start busy", 64'(busy), 64'd1);
        wait_done("ignored start", N - 4);
        check_res("ignored start", 8'h10, 1'b0, 1'b0);
        step();

        // Reset mid-SHIFT aborts the operation with no done pulse.
        issue(8'hAA, 8'h55, 1'b0);
        step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check_res("abort", 8'h00, 1'b0, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 2 * N; i++) begin
            if (done === 1'b1) done_seen++;
            step();
        end
        check("abort no done", 64'(done_seen), 64'd0);
        run_op("after abort", 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

        // start coinciding with reset is lost.
        a     = 8'h01;
        b     = 8'h01;
        start = 1'b1;
        reset = 1'b1;
        step();
        start = 1'b0;
        reset = 1'b0;
        step();
        check("start under reset lost", 64'(busy), 64'd0);

        // Random operands against the arithmetic model.
        for (int i = 0; i < 30; i++) begin
            logic [N-1:0] ra;
            logic [N-1:0] rb;
            logic         rc;
            ra       = N'($urandom);
            rb       = N'($urandom);
            rc       = 1'($urandom);
            ref_full = add_ref(ra, rb, rc);
            run_op($sformatf("rand%0d", i), ra, rb, rc, ref_full[N-1:0], ref_full[N], ovf_ref(ra, rb, rc));
        end

        // N=1 instance: every {a,b,cin} combination, done two edges after start.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] bits;
            int         val;
            int         sval;
            bits   = 3'(i);
            a1     = bits[2];
            b1     = bits[1];
            cin1   = bits[0];
            val    = int'(bits[2]) + int'(bits[1]) + int'(bits[0]);
            sval   = -int'(bits[2]) - int'(bits[1]) + int'(bits[0]);
            start1 = 1'b1;
            step();
            start1 = 1'b0;
            check($sformatf("n1 %0d busy", i), 64'(busy1), 64'd1);
            step();
            check($sformatf("n1 %0d done", i), 64'(done1), 64'd1);
            check($sformatf("n1 %0d result", i), 64'({cout1, sum1}), 64'(val));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("n1 %0d ovf", i), 64'(ovf1), 64'((sval < -1) || (sval > 0)));
`else
            if (sval > 1) $display("note: unexpected n1 value %0d", sval);
`endif
            step();
            check($sformatf("n1 %0d done_pulse", i), 64'(done1), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
